// File: rtl/posit8_pkg.sv
// Shared constants and types for the 8-bit (es=0) posit packer and unpacker.
// uposit layout: {sign, exp biased by EXP_BIAS, frac with the hidden 1 omitted}.
package posit8_pkg;

   localparam int EXP_BIAS = 6;
   localparam int MAX_K    = 6;

   localparam int UPOSIT_W = 10;
   localparam int EXP_W    = 4;
   localparam int FRAC_W   = 5;
   localparam int POSIT_W  = 8;
   localparam int KEPT_W   = 7;
   localparam int MAG_W    = 13;

   localparam int SIGN_BIT = 9;
   localparam int EXP_MSB  = 8;
   localparam int EXP_LSB  = 5;
   localparam int FRAC_MSB = 4;
   localparam int FRAC_LSB = 0;

   localparam logic [POSIT_W-1:0] POSIT_ZERO   = 8'h00;
   localparam logic [POSIT_W-1:0] POSIT_NAR    = 8'h80;
   localparam logic [POSIT_W-1:0] POSIT_MAXPOS = 8'h7F;
   localparam logic [POSIT_W-1:0] POSIT_MINPOS = 8'h01;

   // Stage-1 payload: truncated magnitude plus the bits needed to round it.
   typedef struct packed {
      logic              sign;
      logic [KEPT_W-1:0] kept;
      logic              guard;
      logic              sticky;
      logic              zero;
      logic              nar;
   } s1_t;

endpackage

// File: rtl/posit8_regime_build.sv
// Builds the left-justified regime+fraction string for an es=0 posit and
// splits it into the 7 kept magnitude bits, the guard bit and the sticky bit.
module posit8_regime_build
   import posit8_pkg::*;
(
   input  logic [EXP_W-1:0]  exp,
   input  logic [FRAC_W-1:0] frac,
   output logic [KEPT_W-1:0] kept,
   output logic              guard,
   output logic              sticky
);

   logic [EXP_W-1:0] k_pos;
   logic [EXP_W-1:0] k_neg;
   logic [MAG_W-1:0] mag;

   // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      k_pos = exp - EXP_W'(EXP_BIAS);
      k_neg = EXP_W'(EXP_BIAS) - exp;
      mag   = '0;
      if (exp >= EXP_W'(EXP_BIAS)) begin
         if (k_pos > EXP_W'(MAX_K)) begin
            // Beyond maxpos: pin the kept field to all ones with nothing to round.
            mag = {7'h7F, 6'b0};
         end else begin
            // k+1 ones, a terminating 0, then the fraction.
            mag = ~(13'h1FFF >> (k_pos + 4'd1)) | ({frac, 8'b0} >> (k_pos + 4'd2));
         end
      end else begin
         // -k zeros, a terminating 1, then the fraction.
         mag = {1'b1, frac, 7'b0} >> k_neg;
      end
   end

   assign kept   = mag[MAG_W-1 -: KEPT_W];
   assign guard  = mag[MAG_W-1-KEPT_W];
   assign sticky = |mag[MAG_W-2-KEPT_W:0];

endmodule

// File: rtl/packposit_8bit.sv
// Two-stage valid/ready posit encoder: stage 1 builds regime/fraction bits,
// stage 2 rounds to nearest even with saturation and applies the sign.
module packposit_8bit
   import posit8_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [UPOSIT_W-1:0] uposit,
   input  logic                in_zero,
   input  logic                in_nar,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [POSIT_W-1:0]  posit
);

   s1_t                s1_q, s1_d;
   logic               s1_valid_q, s1_valid_d;
   logic               s2_valid_q, s2_valid_d;
   logic [POSIT_W-1:0] s2_posit_q, s2_posit_d;

   logic               s1_adv;
   logic               in_fire;
   logic [KEPT_W-1:0]  rb_kept;
   logic               rb_guard;
   logic               rb_sticky;

   logic               rnd_up;
   logic [KEPT_W:0]    rnd_sum;
   logic [KEPT_W-1:0]  rnd_mag;
   logic [POSIT_W-1:0] enc;
   logic [POSIT_W-1:0] s2_result;

   posit8_regime_build u_regime_build (
      .exp    (uposit[EXP_MSB:EXP_LSB]),
      .frac   (uposit[FRAC_MSB:FRAC_LSB]),
      .kept   (rb_kept),
      .guard  (rb_guard),
      .sticky (rb_sticky)
   );

   // Stage 1 may move whenever stage 2 is empty or draining this cycle.
   assign s1_adv   = !s2_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s1_adv;
   assign in_fire  = in_valid && in_ready;

   always_comb begin
      s1_valid_d = in_ready ? in_valid : s1_valid_q;
      s1_d       = s1_q;
      if (in_fire) begin
         s1_d.sign   = uposit[SIGN_BIT];
         s1_d.kept   = rb_kept;
         s1_d.guard  = rb_guard;
         s1_d.sticky = rb_sticky;
         s1_d.zero   = in_zero;
         s1_d.nar    = in_nar;
      end
   end

   always_comb begin
      rnd_up  = s1_q.guard && (s1_q.sticky || s1_q.kept[0]);
      rnd_sum = {1'b0, s1_q.kept} + {{KEPT_W{1'b0}}, rnd_up};
      if (rnd_sum[KEPT_W]) begin
         rnd_mag = POSIT_MAXPOS[KEPT_W-1:0];
      end else if (rnd_sum[KEPT_W-1:0] == '0) begin
         rnd_mag = POSIT_MINPOS[KEPT_W-1:0];
      end else begin
         rnd_mag = rnd_sum[KEPT_W-1:0];
      end

      enc = {1'b0, rnd_mag};
      if (s1_q.sign) begin
         enc = ~enc + 8'd1;
      end

      if (s1_q.nar) begin
         s2_result = POSIT_NAR;
      end else if (s1_q.zero) begin
         s2_result = POSIT_ZERO;
      end else begin
         s2_result = enc;
      end
   end

   always_comb begin
      s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
      s2_posit_d = s2_posit_q;
      if (s1_adv && s1_valid_q) begin
         s2_posit_d = s2_result;
      end
   end

   // NOTE: the datapath registers are reset too, so the posit output reads 8'h00 whenever reset is asserted.
   // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         s2_valid_q <= 1'b0;
         s2_posit_q <= POSIT_ZERO;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_q       <= s1_d;
         s2_valid_q <= s2_valid_d;
         s2_posit_q <= s2_posit_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign posit     = s2_posit_q;

endmodule

// File: tb/tb_packposit_8bit.sv
// Scoreboard bench for packposit_8bit: directed encodings, rounding, saturation,
// flags, backpressure, mid-stream reset and a full 256-posit round trip.
module tb_packposit_8bit;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [9:0] uposit;
   logic       in_zero;
   logic       in_nar;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] posit;

   typedef struct {
      logic [7:0] val;
      int         cyc;
      bit         lat;
   } sb_t;

   sb_t sb[$];
   int  checks   = 0;
   int  errors   = 0;
   int  cyc      = 0;
   int  accepted = 0;
   bit  rr_done;

   packposit_8bit dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .uposit    (uposit),
      .in_zero   (in_zero),
      .in_nar    (in_nar),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .posit     (posit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   // Reference decoder: posit -> {zero, nar, uposit}.
   function automatic logic [11:0] decode(input logic [7:0] p);
      logic [7:0] t;
      logic [6:0] m;
      logic [4:0] f;
      logic       lead;
      int         run;
      int         k;
      int         nf;
      if (p == 8'h00) return {2'b10, 10'd0};
      if (p == 8'h80) return {2'b01, 10'd0};
      t    = p[7] ? (~p + 8'd1) : p;
      m    = t[6:0];
      lead = m[6];
      run  = 0;
      for (int i = 6; i >= 0; i--) begin
         if (m[i] == lead) run++;
         else break;
      end
      k  = lead ? run - 1 : -run;
      nf = 6 - run;
      if (nf < 0) nf = 0;
      f = '0;
      for (int i = 0; i < nf; i++) f[4-i] = m[nf-1-i];
      return {2'b00, p[7], 4'(k + 6), f};
   endfunction

   // Transfers are decided at the negedge, when out_valid/out_ready are stable.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_output", sb.size(), 1);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("data", posit, e.val);
            if (e.lat) check("latency", cyc - e.cyc, 2);
         end
      end
   end

   task automatic send(input logic [9:0] u, input logic z, input logic n,
                       input logic [7:0] e, input bit lat);
      int  waited;
      bit  ok;
      waited   = 0;
      ok       = 1'b0;
      uposit   = u;
      in_zero  = z;
      in_nar   = n;
      in_valid = 1'b1;
      while (!ok && waited < 200) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waited++;
      end
      if (ok) begin
         sb.push_back('{e, cyc, lat});
         accepted++;
      end else begin
         check("in_ready_timeout", in_ready, 1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 300) begin
         @(posedge clk); #1;
         waited++;
      end
      check("drain", sb.size(), 0);
   endtask

   task automatic one(input logic [9:0] u, input logic z, input logic n, input logic [7:0] e);
      send(u, z, n, e, 1'b1);
      drain();
   endtask

   initial begin
      logic [11:0] d;
      int          acc0;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      uposit    = '0;
      in_zero   = 1'b0;
      in_nar    = 1'b0;
      out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_posit", posit, 8'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_in_ready", in_ready, 1);

      // Basic encodings, each with a latency check.
      one(10'h118, 0, 0, 8'h76);
      one(10'h0D7, 0, 0, 8'h57);
      one(10'h08C, 0, 0, 8'h16);
      one(10'h318, 0, 0, 8'h8A);
      one(10'h2D7, 0, 0, 8'hA9);
      // Rounding at exp 8.
      one(10'h11A, 0, 0, 8'h76);
      one(10'h11E, 0, 0, 8'h78);
      one(10'h11B, 0, 0, 8'h77);
      // Saturation and minpos territory.
      one(10'h1E0, 0, 0, 8'h7F);
      one(10'h3E0, 0, 0, 8'h81);
      one(10'h19F, 0, 0, 8'h7F);
      one(10'h000, 0, 0, 8'h01);
      one(10'h01F, 0, 0, 8'h02);
      // Flags, with garbage in the uposit field.
      one(10'h2D7, 1, 0, 8'h00);
      one(10'h118, 0, 1, 8'h80);
      one(10'h3FF, 1, 1, 8'h80);

      // Backpressure: out_ready low for 5 cycles while 4 words are offered.
      acc0 = accepted;
      fork
         begin
            send(10'h118, 0, 0, 8'h76, 1'b0);
            send(10'h0D7, 0, 0, 8'h57, 1'b0);
            send(10'h08C, 0, 0, 8'h16, 1'b0);
            send(10'h318, 0, 0, 8'h8A, 1'b0);
         end
         begin
            out_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               if (out_valid) check("hold_posit", posit, 8'h76);
               @(posedge clk); #1;
            end
            check("bp_accepts", accepted - acc0, 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            out_ready = 1'b1;
         end
      join
      drain();

      // Mid-stream reset discards in-flight words at once.
      out_ready = 1'b0;
      send(10'h0D7, 0, 0, 8'h57, 1'b0);
      send(10'h08C, 0, 0, 8'h16, 1'b0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_posit", posit, 8'h00);
      sb.delete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("midrst_in_ready", in_ready, 1);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_no_output", out_valid, 0);

      // Round trip of every posit through the reference decoder, with random backpressure.
      rr_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 256; p++) begin
               d = decode(8'(p));
               send(d[9:0] ^ (d[11] ? 10'h2A5 : 10'h000), d[11], d[10], 8'(p), 1'b0);
            end
            rr_done = 1'b1;
         end
         begin
            while (!rr_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
